rice_partition_scheduler: RTL and testbench
===========================================

Name: rice_partition_scheduler

Overview:
- Sequences the variable Rice encoder for one channel.
- Buffers residuals in ping-pong partitions of 2^PART_ORDER samples and accumulates the sum of absolute values.
- Searches for the FLAC-estimate Rice parameter, then replays the partition to the encoder with that parameter held stable.
- Sits between the residual-producing FIR stage and the variable Rice encoder.

Parameters:
DATA_W, 16, residual width (signed, two's complement)
PART_ORDER, 4, log2 of partition size; PART_SIZE = 2^PART_ORDER = 16
MAX_K, 14, largest Rice parameter emitted; the search caps here

Ports:
iClock  in  1  clock, rising edge
iReset  in  1  asynchronous, active-low reset (0 = reset)
iValid  in  1  iSample is valid; accepted when iValid && oReady
iSample  in  DATA_W  signed residual
iLast  in  1  qualifies an accepted sample as the final sample of the block; flushes a partial partition
oReady  out  1  a write bank is free
oValid  out  1  oSample is valid for the encoder
oSample  out  DATA_W  residual replayed to the encoder
oRiceParam  out  4  Rice parameter for the current partition; stable while oValid
oParamValid  out  1  one-cycle pulse coincident with the first oValid of a partition
oPartitionDone  out  1  one-cycle pulse coincident with the last oValid of a partition

Behaviour:
- Reset (iReset=0, async):
  - All outputs 0, except oReady=1.
  - Both banks empty; write and read FSMs idle; sums and counts cleared.
  - Reset mid-fill or mid-emit discards all buffered data.
- Storage: two banks of PART_SIZE x DATA_W, synchronous read. Each bank has a full flag, count N (1..PART_SIZE) and sum S.
- S width is DATA_W+PART_ORDER+1. |x| is computed at DATA_W+1 bits, so |-32768| = 32768 exactly; S never overflows.
- Write side:
  - Each accepted sample goes to wbank[wptr]; S += |x|; wptr++.
  - On wptr == PART_SIZE-1 or iLast: mark bank full with N = wptr+1, toggle wbank, clear wptr and the accumulator.
  - oReady = 0 iff the next write bank is still full (both banks full). No sample is ever dropped.
- Read FSM states:
  - IDLE: when rbank is full -> CALC, with k=0.
  - CALC:
    - Each cycle evaluates (N << k) >= S.
    - If true, or k == MAX_K: latch oRiceParam = k, go to EMIT.
    - Otherwise k++.
    - Search takes k_final+1 cycles.
  - EMIT:
    - Issues read addresses 0..N-1, one per cycle.
    - oValid and oSample follow each address by 1 cycle, so the first oValid is 2 cycles after the terminating CALC cycle.
    - oParamValid pulses with sample 0; oPartitionDone pulses with sample N-1.
    - After the last address: clear the bank's full flag, toggle rbank, go to IDLE.
    - The freed bank may be refilled from the following cycle.
- The encoder always accepts; there is no output backpressure. oValid is contiguous for the N samples of a partition.
- Simultaneous events:
  - The write side filling a bank in the same cycle the read side frees the other bank: both take effect; oReady stays 1.
  - iLast on a sample that also fills the bank: a single partition with N = PART_SIZE.
  - iLast with no pending samples has no effect (iLast is only sampled with an accepted sample).
- Output ordering equals input ordering across partitions.

Optional Feature:
RICE_PARAM_OVERRIDE_EN
- Defined: adds ports iOverrideEn (in, 1) and iOverrideParam (in, 4).
  - If iOverrideEn=1 when CALC is entered, CALC lasts exactly 1 cycle.
  - oRiceParam = min(iOverrideParam, MAX_K); the sum is ignored.
- Undefined: ports absent; the search always runs.

Test Plan:
- 16 x 0 -> S=0, k=0; 16 zeros out; oParamValid with the first, oPartitionDone with the last; first oValid 3 cycles after the 16th write (one CALC cycle + 2).
- 16 x 20 -> S=320; 256<320<=512 -> oRiceParam=5; 16 outputs of 20.
- Alternating -123/123 x16 -> S=1968 -> oRiceParam=7; order preserved, signs intact.
- 16 x -32768 -> S=524288 needs k=15; capped -> oRiceParam=14; outputs all -32768.
- 5 x 100 with iLast on the 5th -> N=5, S=500 -> oRiceParam=7; exactly 5 outputs; oPartitionDone on the 5th; the next partition starts at wptr 0.
- 64 continuous -32768 samples with iValid held 1:
  - oReady drops low at least once.
  - All 64 samples emerge in order as 4 partitions, each with oRiceParam=14.
  - iReset pulsed low mid-emit -> oValid=0 immediately; oReady=1; no stale output after release.

Source files
------------

// File: rtl/rice_partition_scheduler.sv
// rtl/rice_partition_scheduler.sv - ping-pong residual partitions, Rice parameter search and replay
// Optional RICE_PARAM_OVERRIDE_EN adds iOverrideEn/iOverrideParam to bypass the search.
module rice_partition_scheduler #(
  parameter int DATA_W     = 16,
  parameter int PART_ORDER = 4,
  parameter int MAX_K      = 14
) (
  input  logic                     iClock,
  input  logic                     iReset,
  input  logic                     iValid,
  input  logic signed [DATA_W-1:0] iSample,
  input  logic                     iLast,
`ifdef RICE_PARAM_OVERRIDE_EN
  input  logic                     iOverrideEn,
  input  logic [3:0]               iOverrideParam,
`endif
  output logic                     oReady,
  output logic                     oValid,
  output logic signed [DATA_W-1:0] oSample,
  output logic [3:0]               oRiceParam,
  output logic                     oParamValid,
  output logic                     oPartitionDone
);

  localparam int PART_SIZE = 1 << PART_ORDER;
  localparam int SUM_W     = DATA_W + PART_ORDER + 1;
  localparam int CNT_W     = PART_ORDER + 1;
  localparam int CMP_W     = SUM_W + 16;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_EMIT} state_t;

  logic signed [DATA_W-1:0] r_mem [2][PART_SIZE];
  logic signed [DATA_W-1:0] r_rdata;
  logic [1:0]               r_full;
  logic [CNT_W-1:0]         r_cnt [2];
  logic [SUM_W-1:0]         r_sum [2];
  logic                     r_wbank;
  logic                     r_rbank;
  logic [PART_ORDER-1:0]    r_wptr;
  logic [PART_ORDER-1:0]    r_raddr;
  logic [SUM_W-1:0]         r_acc;
  state_t                   r_state;
  logic [3:0]               r_k;

  logic                     w_accept;
  logic                     w_close;
  logic [DATA_W:0]          w_ext;
  logic [DATA_W:0]          w_abs;
  logic [SUM_W-1:0]         w_acc_next;
  logic [CMP_W-1:0]         w_nshift;
  logic                     w_k_done;
  logic                     w_last_addr;
  logic                     w_start;
  logic                     w_ovr;
  logic [3:0]               w_ovr_k;

  assign oReady     = ~r_full[r_wbank];
  assign w_accept   = iValid && oReady;
  assign w_close    = w_accept && ((r_wptr == {PART_ORDER{1'b1}}) || iLast);
  // One extra bit keeps |-2^(DATA_W-1)| exact.
  assign w_ext      = {iSample[DATA_W-1], iSample};
  assign w_abs      = iSample[DATA_W-1] ? (~w_ext + 1'b1) : w_ext;
  assign w_acc_next = r_acc + {{(SUM_W-DATA_W-1){1'b0}}, w_abs};

  assign w_nshift    = CMP_W'(r_cnt[r_rbank]) << r_k;
  assign w_k_done    = (w_nshift >= CMP_W'(r_sum[r_rbank])) || (r_k == 4'(MAX_K));
  assign w_last_addr = ({1'b0, r_raddr} == (r_cnt[r_rbank] - 1'b1));
  // A bank closing this cycle starts the search without an idle bubble.
  assign w_start     = r_full[r_rbank] || (w_close && (r_wbank == r_rbank));

`ifdef RICE_PARAM_OVERRIDE_EN
  assign w_ovr   = iOverrideEn && (r_k == 4'd0);
  assign w_ovr_k = (iOverrideParam > 4'(MAX_K)) ? 4'(MAX_K) : iOverrideParam;
`else
  assign w_ovr   = 1'b0;
  assign w_ovr_k = 4'd0;
`endif

  assign oSample = oValid ? r_rdata : '0;

  always_ff @(posedge iClock) begin
    if (w_accept) begin
      r_mem[r_wbank][r_wptr] <= iSample;
    end
    r_rdata <= r_mem[r_rbank][r_raddr];
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_full         <= '0;
      r_cnt[0]       <= '0;
      r_cnt[1]       <= '0;
      r_sum[0]       <= '0;
      r_sum[1]       <= '0;
      r_wbank        <= 1'b0;
      r_rbank        <= 1'b0;
      r_wptr         <= '0;
      r_raddr        <= '0;
      r_acc          <= '0;
      r_state        <= S_IDLE;
      r_k            <= '0;
      oValid         <= 1'b0;
      oRiceParam     <= '0;
      oParamValid    <= 1'b0;
      oPartitionDone <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_close) begin
          r_full[r_wbank] <= 1'b1;
          r_cnt[r_wbank]  <= {1'b0, r_wptr} + 1'b1;
          r_sum[r_wbank]  <= w_acc_next;
          r_wbank         <= ~r_wbank;
          r_wptr          <= '0;
          r_acc           <= '0;
        end else begin
          r_wptr <= r_wptr + 1'b1;
          r_acc  <= w_acc_next;
        end
      end

      oValid         <= (r_state == S_EMIT);
      oParamValid    <= (r_state == S_EMIT) && (r_raddr == '0);
      oPartitionDone <= (r_state == S_EMIT) && w_last_addr;

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_CALC;
            r_k     <= '0;
          end
        end
        S_CALC: begin
          if (w_ovr) begin
            oRiceParam <= w_ovr_k;
            r_state    <= S_EMIT;
            r_raddr    <= '0;
          end else if (w_k_done) begin
            oRiceParam <= r_k;
            r_state    <= S_EMIT;
            r_raddr    <= '0;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_EMIT: begin
          if (w_last_addr) begin
            r_full[r_rbank] <= 1'b0;
            r_rbank         <= ~r_rbank;
            r_state         <= S_IDLE;
          end else begin
            r_raddr <= r_raddr + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rice_partition_scheduler.sv
// tb/tb_rice_partition_scheduler.sv - scoreboard bench for rice_partition_scheduler
module tb_rice_partition_scheduler;

  logic               iClock = 1'b0;
  logic               iReset = 1'b0;
  logic               iValid = 1'b0;
  logic signed [15:0] iSample = '0;
  logic               iLast = 1'b0;
  logic               oReady;
  logic               oValid;
  logic signed [15:0] oSample;
  logic [3:0]         oRiceParam;
  logic               oParamValid;
  logic               oPartitionDone;

  rice_partition_scheduler dut (
    .iClock        (iClock),
    .iReset        (iReset),
    .iValid        (iValid),
    .iSample       (iSample),
    .iLast         (iLast),
    .oReady        (oReady),
    .oValid        (oValid),
    .oSample       (oSample),
    .oRiceParam    (oRiceParam),
    .oParamValid   (oParamValid),
    .oPartitionDone(oPartitionDone)
  );

  always #5 iClock = ~iClock;

  typedef struct packed {
    logic [15:0] s;
    logic [3:0]  k;
    logic        first;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   out_count = 0;
  int   first_valid_cyc = -1;
  bit   track_first = 0;
  bit   saw_not_ready = 0;

  always @(posedge iClock) cyc <= cyc + 1;

  always @(negedge iClock) begin
    exp_t e;
    if (iReset) begin
      if (!oReady) saw_not_ready = 1;
      if (oValid) begin
        out_count++;
        if (track_first) begin
          first_valid_cyc = cyc;
          track_first = 0;
        end
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_output got s=%0d k=%0d, required no output", oSample, oRiceParam);
        end else begin
          e = q.pop_front();
          if ({oSample, oRiceParam, oParamValid, oPartitionDone} !== e) begin
            miscompares++;
            $display("FAIL output got s=%0d k=%0d pv=%0b pd=%0b, required s=%0d k=%0d pv=%0b pd=%0b",
                     oSample, oRiceParam, oParamValid, oPartitionDone,
                     $signed(e.s), e.k, e.first, e.last);
          end
        end
      end else if (oParamValid || oPartitionDone) begin
        vectors++;
        miscompares++;
        $display("FAIL strobe_without_valid got pv=%0b pd=%0b, required 0 0", oParamValid, oPartitionDone);
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic send(input logic signed [15:0] s, input logic last, output int acc_cyc);
    bit rdy = 0;
    int n = 0;
    acc_cyc = -1;
    iValid = 1'b1;
    iSample = s;
    iLast = last;
    while (!rdy && n < 500) begin
      @(negedge iClock);
      rdy = oReady;
      acc_cyc = cyc;
      @(posedge iClock);
      #1;
      n++;
    end
    if (!rdy) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout got oReady=0 for %0d cycles, required acceptance", n);
    end
    iValid = 1'b0;
    iLast = 1'b0;
  endtask

  task automatic part_const(input logic signed [15:0] v, input int n, input logic [3:0] k,
                            input bit use_last, output int last_cyc);
    for (int i = 0; i < n; i++) begin
      q.push_back({v, k, (i == 0), (i == n - 1)});
      send(v, use_last && (i == n - 1), last_cyc);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(posedge iClock);
      n++;
    end
    repeat (3) @(posedge iClock);
    #1;
    chk({name, "_drained_remaining"}, q.size(), 0);
  endtask

  initial begin
    int c;
    int seen;
    int n;
    logic signed [15:0] v;

    repeat (3) @(posedge iClock);
    @(negedge iClock);
    chk("reset_oReady", oReady, 1);
    chk("reset_oValid", oValid, 0);
    chk("reset_oSample", oSample, 0);
    chk("reset_oRiceParam", oRiceParam, 0);
    chk("reset_oParamValid", oParamValid, 0);
    chk("reset_oPartitionDone", oPartitionDone, 0);
    @(posedge iClock);
    #1;
    iReset = 1'b1;
    repeat (2) @(posedge iClock);
    #1;

    track_first = 1;
    part_const(16'sd0, 16, 4'd0, 0, c);
    drain("zeros");
    chk("zeros_first_valid_latency", first_valid_cyc - c, 3);

    part_const(16'sd20, 16, 4'd5, 1, c);
    drain("twenty_last_on_full");

    for (int i = 0; i < 16; i++) begin
      v = (i % 2 == 0) ? -16'sd123 : 16'sd123;
      q.push_back({v, 4'd7, (i == 0), (i == 15)});
      send(v, 1'b0, c);
    end
    drain("alternating_123");

    part_const(-16'sd32768, 16, 4'd14, 0, c);
    drain("min_capped");

    iLast = 1'b1;
    repeat (3) @(posedge iClock);
    #1;
    iLast = 1'b0;
    part_const(16'sd100, 5, 4'd7, 1, c);
    drain("five_flush");
    part_const(16'sd20, 16, 4'd5, 0, c);
    drain("after_flush");

    saw_not_ready = 0;
    for (int p = 0; p < 4; p++) part_const(-16'sd32768, 16, 4'd14, 0, c);
    drain("stream64");
    chk("stream64_oReady_dropped", saw_not_ready, 1);

    part_const(16'sd7, 16, 4'd3, 0, c);
    n = 0;
    while (!oValid && n < 200) begin
      @(negedge iClock);
      n++;
    end
    chk("reset_test_emit_started", oValid, 1);
    @(posedge iClock);
    #1;
    iReset = 1'b0;
    #1;
    chk("midemit_reset_oValid", oValid, 0);
    chk("midemit_reset_oReady", oReady, 1);
    chk("midemit_reset_oRiceParam", oRiceParam, 0);
    q.delete();
    repeat (2) @(posedge iClock);
    #1;
    iReset = 1'b1;
    seen = out_count;
    repeat (40) @(posedge iClock);
    #1;
    chk("no_stale_output_after_reset", out_count - seen, 0);
    part_const(16'sd100, 5, 4'd7, 1, c);
    drain("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
